gnr_attractor_ctrl: RTL and testbench
=====================================

// Module: gnr_attractor_ctrl
// PURPOSE
//  Initiator/controller for an array of dual-copy Boolean GNR nodes.
//  - Each node keeps s0 (slow copy, steps on every other start_s0) and s1 (fast copy, steps on every start_s1).
//  - The block loads an initial state vector into all nodes and runs Floyd tortoise/hare stepping.
//  - It detects s0==s1, then holds s0 and steps s1 alone to measure the attractor period.
//  - It reports the transient step count, the period, and a timeout flag to the host.
// PARAMETERS
//  N_NODES    8    number of nodes; width of state vectors
//  CNT_W      16   width of step and period counters
//  MAX_STEPS  1000 pulse limit per phase before timeout (must be < 2**CNT_W)
// PORTS
//  clk              in   1        clock
//  rst              in   1        async active-high reset
//  start            in   1        1-cycle request; accepted only in IDLE
//  init_vec         in   N_NODES  initial network state; sampled when start is accepted
//  state_s0         in   N_NODES  concatenated node s0 outputs (registered in nodes)
//  state_s1         in   N_NODES  concatenated node s1 outputs (registered in nodes)
//  reset_nos        out  1        to all nodes: load init_state, reset pass flag
//  init_state       out  N_NODES  bit i drives init_state of node i
//  start_s0         out  1        step request for the s0 copies
//  start_s1         out  1        step request for the s1 copies
//  busy             out  1        high from LOAD through PERIOD
//  done             out  1        1-cycle pulse when the result is final
//  found            out  1        attractor found; held until next accepted start
//  timeout          out  1        limit reached; held until next accepted start
//  transient_steps  out  CNT_W    pulse count k at which s0==s1 was detected
//  period           out  CNT_W    attractor period (0 if not found)
// BEHAVIOUR
//  Reset values (rst high, async)
//   - FSM goes to IDLE.
//   - All outputs and counters go to 0. init_state goes to 0.
//   - Reset mid-operation abandons the run. No done pulse is issued.
//  FSM states: IDLE -> LOAD -> RUN -> PERIOD -> DONE -> IDLE
//  IDLE
//   - On start: latch init_vec into init_state.
//   - Clear found, timeout, transient_steps, period, run_cnt and per_cnt.
//   - Go to LOAD.
//   - start in any other state is ignored.
//  LOAD (one cycle)
//   - reset_nos=1. start_s0 and start_s1 are 0.
//   - Go to RUN.
//  RUN
//   - run_cnt = pulses already issued.
//   - hit = (run_cnt>=2) && (state_s0==state_s1). The test is gated because after 1 pulse both copies are trivially equal.
//   - start_s0 = start_s1 = !hit && (run_cnt!=MAX_STEPS). This is combinational (Mealy); node outputs are registered, so no loop.
//   - When pulsing: run_cnt++ per cycle.
//   - On hit: transient_steps<=run_cnt, found<=1, go to PERIOD.
//   - If run_cnt==MAX_STEPS and no hit: timeout<=1, go to DONE.
//  PERIOD
//   - start_s0=0, so s0 is frozen at the meeting state. start_s1 = !phit && (per_cnt!=MAX_STEPS).
//   - phit = (per_cnt>=1) && (state_s0==state_s1).
//   - On phit: period<=per_cnt, go to DONE.
//   - If per_cnt==MAX_STEPS: timeout<=1, period<=0, go to DONE. found stays 1.
//  DONE (one cycle)
//   - done=1, busy=0. Go to IDLE.
//   - Results are held until the next accepted start.
//  Step semantics (nodes)
//   - After k RUN pulses: s1=f^k(x), s0=f^ceil(k/2)(x).
//   - A pulse issued in cycle t is visible on state_s* in cycle t+1.
//  Counter and width rules
//   - Counters saturate at MAX_STEPS; they never wrap.
//   - Compare is a full N_NODES-bit equality.
//  Latency
//   - start to first pulse = 2 cycles (accept, LOAD).
//   - done follows the final compare by 1 cycle.
// TESTING
//  1) Fixed point: bench net f(x)=x, init_vec=8'h5A.
//     -> reset_nos pulses 1 cycle after start. hit at run_cnt=2.
//     -> found=1, transient_steps=2, period=1, timeout=0, one done pulse.
//  2) 3-node rotate-left ring (N_NODES=3), init 3'b001.
//     -> transient_steps=6, period=3, found=1.
//     -> exactly 6 start_s1 pulses in RUN and 3 in PERIOD; no start_s0 in PERIOD.
//  3) Timeout: same ring with MAX_STEPS=4.
//     -> exactly 4 pulses, then done with timeout=1, found=0, period=0.
//  4) start re-asserted during RUN with a different init_vec.
//     -> ignored: init_state is unchanged and results match scenario 2.
//  5) Async rst raised mid-RUN, off a clock edge.
//     -> outputs 0 immediately, FSM in IDLE, no done pulse.
//     -> a new start then produces correct results.
//  6) Back-to-back runs: start in the cycle after done.
//     -> accepted. found/timeout/period clear on accept. The new LOAD pulse is seen.

Source files
------------

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
// Drives an array of dual-copy Boolean GNR nodes. The slow copy (s0) and the
// fast copy (s1) run as Floyd tortoise/hare until they meet. s0 is then frozen
// and s1 steps alone to measure the attractor period. The block reports the
// meeting step count, the period, and a timeout flag.
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] state_s0,
  input  logic [N_NODES-1:0] state_s1,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               timeout,
  output logic [CNT_W-1:0]   transient_steps,
  output logic [CNT_W-1:0]   period
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PERIOD,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);

  state_e state_q, state_d;

  logic [N_NODES-1:0] initState_q, initState_d;
  logic [CNT_W-1:0]   runCnt_q, runCnt_d;
  logic [CNT_W-1:0]   perCnt_q, perCnt_d;
  logic [CNT_W-1:0]   transient_q, transient_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               found_q, found_d;
  logic               timeout_q, timeout_d;

  logic stateEq;
  logic hit;
  logic pHit;
  logic runLim;
  logic perLim;

  // Meeting detection; the RUN test ignores the first two pulse counts because
  // after a single pulse both copies are trivially identical.
  always_comb begin
    stateEq = (state_s0 == state_s1);
    hit     = (state_q == RUN) && (runCnt_q >= CNT_W'(2)) && stateEq;
    pHit    = (state_q == PERIOD) && (perCnt_q >= CNT_W'(1)) && stateEq;
    runLim  = (runCnt_q == MaxCnt);
    perLim  = (perCnt_q == MaxCnt);
  end

  // State register plus the result/counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      initState_q <= '0;
      runCnt_q    <= '0;
      perCnt_q    <= '0;
      transient_q <= '0;
      period_q    <= '0;
      found_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      initState_q <= initState_d;
      runCnt_q    <= runCnt_d;
      perCnt_q    <= perCnt_d;
      transient_q <= transient_d;
      period_q    <= period_d;
      found_q     <= found_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic for the FSM and its counters/results.
  always_comb begin
    state_d     = state_q;
    initState_d = initState_q;
    runCnt_d    = runCnt_q;
    perCnt_d    = perCnt_q;
    transient_d = transient_q;
    period_d    = period_q;
    found_d     = found_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          initState_d = init_vec;
          runCnt_d    = '0;
          perCnt_d    = '0;
          transient_d = '0;
          period_d    = '0;
          found_d     = 1'b0;
          timeout_d   = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (hit) begin
          transient_d = runCnt_q;
          found_d     = 1'b1;
          state_d     = PERIOD;
        end else if (runLim) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          runCnt_d = runCnt_q + CNT_W'(1);
        end
      end
      PERIOD: begin
        if (pHit) begin
          period_d = perCnt_q;
          state_d  = DONE;
        end else if (perLim) begin
          timeout_d = 1'b1;
          period_d  = '0;
          state_d   = DONE;
        end else begin
          perCnt_d = perCnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mealy outputs; node states are registered so stepping has no comb loop.
  always_comb begin
    reset_nos = (state_q == LOAD);
    busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == PERIOD);
    done      = (state_q == DONE);
    start_s0  = (state_q == RUN) && !hit && !runLim;
    start_s1  = ((state_q == RUN) && !hit && !runLim) ||
                ((state_q == PERIOD) && !pHit && !perLim);
  end

  assign init_state      = initState_q;
  assign found           = found_q;
  assign timeout         = timeout_q;
  assign transient_steps = transient_q;
  assign period          = period_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb_gnr_attractor_ctrl
// Bench with a behavioural GNR node array (several selectable update rules)
// and a rho-sequence reference model computed directly from iterated f.
module tb_gnr_attractor_ctrl;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int MAXS = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] init_vec;
  logic [N-1:0] state_s0;
  logic [N-1:0] state_s1;
  logic         reset_nos;
  logic [N-1:0] init_state;
  logic         start_s0;
  logic         start_s1;
  logic         busy;
  logic         done;
  logic         found;
  logic         timeout;
  logic [W-1:0] transient_steps;
  logic [W-1:0] period;

  gnr_attractor_ctrl #(
    .N_NODES  (N),
    .CNT_W    (W),
    .MAX_STEPS(MAXS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .init_vec       (init_vec),
    .state_s0       (state_s0),
    .state_s1       (state_s1),
    .reset_nos      (reset_nos),
    .init_state     (init_state),
    .start_s0       (start_s0),
    .start_s1       (start_s1),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .timeout        (timeout),
    .transient_steps(transient_steps),
    .period         (period)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           fails = 0;
  int           fMode = 0;
  logic [7:0]   randTab [256];
  logic         passFlag;
  int           bothCnt = 0;
  int           s1OnlyCnt = 0;
  int           s0OnlyCnt = 0;
  int           doneCount = 0;
  int           runsDone = 0;

  // Network update rule: 0 identity, 1 3-bit rotate-left ring, 2 increment,
  // otherwise a random map on the low nibble.
  function automatic logic [7:0] fStep(input int mode, input logic [7:0] x);
    logic [7:0] t;
    case (mode)
      0: return x;
      1: return {x[7:3], x[1:0], x[2]};
      2: return x + 8'd1;
      default: begin
        t = randTab[x];
        return {x[7:4], t[3:0]};
      end
    endcase
  endfunction

  function automatic logic [7:0] fPow(input int mode, input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = fStep(mode, y);
    return y;
  endfunction

  // Reference: first k>=2 with f^k(x)==f^ceil(k/2)(x), then smallest period.
  task automatic modelRun(input int mode, input logic [7:0] v,
                          output int eF, output int eK, output int eP,
                          output int eT, output int eRun, output int ePer);
    logic [7:0] m;
    eF = 0; eK = 0; eP = 0; eT = 0; eRun = MAXS; ePer = 0;
    for (int k = 2; k <= MAXS && eF == 0; k++) begin
      if (fPow(mode, v, k) == fPow(mode, v, (k + 1) / 2)) begin
        eF = 1; eK = k; eRun = k;
      end
    end
    if (eF == 0) begin
      eT = 1;
    end else begin
      m = fPow(mode, v, (eK + 1) / 2);
      eT = 1; ePer = MAXS;
      for (int p = 1; p <= MAXS && eT == 1; p++) begin
        if (fPow(mode, m, p) == m) begin
          eP = p; ePer = p; eT = 0;
        end
      end
    end
  endtask

  // Behavioural node array: s0 steps on every other start_s0, s1 on every start_s1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      state_s0 <= '0;
      state_s1 <= '0;
      passFlag <= 1'b0;
    end else if (reset_nos) begin
      state_s0 <= init_state;
      state_s1 <= init_state;
      passFlag <= 1'b0;
    end else begin
      if (start_s0) begin
        if (!passFlag) state_s0 <= fStep(fMode, state_s0);
        passFlag <= ~passFlag;
      end
      if (start_s1) state_s1 <= fStep(fMode, state_s1);
    end
  end

  // Pulse and done counters sampled away from the active edge.
  always @(negedge clk) begin
    if (start_s0 && start_s1) bothCnt++;
    else if (start_s1) s1OnlyCnt++;
    else if (start_s0) s0OnlyCnt++;
    if (done) doneCount++;
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete run from start to done, checked against the reference model.
  task automatic applyStimulus(input int mode, input logic [7:0] v, input bit glitch);
    int eF, eK, eP, eT, eRun, ePer;
    int b0, b1, b2;
    bit seen;
    modelRun(mode, v, eF, eK, eP, eT, eRun, ePer);
    @(negedge clk);
    fMode    = mode;
    start    = 1'b1;
    init_vec = v;
    @(negedge clk);
    start    = 1'b0;
    init_vec = 8'($urandom);
    #1;
    b0 = bothCnt; b1 = s1OnlyCnt; b2 = s0OnlyCnt;
    checkOutput("load_reset_nos", int'(reset_nos), 1);
    checkOutput("load_no_pulse", int'(start_s1), 0);
    checkOutput("load_busy", int'(busy), 1);
    checkOutput("clr_found", int'(found), 0);
    checkOutput("clr_timeout", int'(timeout), 0);
    checkOutput("clr_period", int'(period), 0);
    checkOutput("clr_transient", int'(transient_steps), 0);
    checkOutput("load_init_state", int'(init_state), int'(v));
    checkOutput("done_pulses_so_far", doneCount, runsDone);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (glitch) begin
        if (i == 3) begin
          start    = 1'b1;
          init_vec = ~v;
        end else begin
          start = 1'b0;
        end
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput("done_seen", int'(seen), 1);
    runsDone++;
    checkOutput("res_found", int'(found), eF);
    checkOutput("res_timeout", int'(timeout), eT);
    checkOutput("res_transient", int'(transient_steps), eK);
    checkOutput("res_period", int'(period), eP);
    checkOutput("res_busy_low", int'(busy), 0);
    checkOutput("res_init_state", int'(init_state), int'(v));
    checkOutput("run_pulses", bothCnt - b0, eRun);
    checkOutput("period_pulses", s1OnlyCnt - b1, ePer);
    checkOutput("s0_alone_pulses", s0OnlyCnt - b2, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    init_vec = '0;
    for (int i = 0; i < 256; i++) randTab[i] = 8'($urandom);
    #12;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_found", int'(found), 0);
    checkOutput("rst_reset_nos", int'(reset_nos), 0);
    checkOutput("rst_init_state", int'(init_state), 0);
    checkOutput("rst_period", int'(period), 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 8'h5A, 1'b0);
    checkOutput("fp_transient", int'(transient_steps), 2);
    checkOutput("fp_period", int'(period), 1);

    applyStimulus(1, 8'h01, 1'b0);
    checkOutput("ring_transient", int'(transient_steps), 6);
    checkOutput("ring_period", int'(period), 3);

    applyStimulus(2, 8'h00, 1'b0);
    checkOutput("tmo_flag", int'(timeout), 1);

    applyStimulus(1, 8'h01, 1'b1);
    checkOutput("glitch_transient", int'(transient_steps), 6);
    checkOutput("glitch_period", int'(period), 3);

    @(negedge clk);
    fMode    = 1;
    start    = 1'b1;
    init_vec = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_start_s1", int'(start_s1), 0);
    checkOutput("arst_init_state", int'(init_state), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("arst_no_done", doneCount, runsDone);
    checkOutput("arst_idle", int'(busy), 0);

    applyStimulus(1, 8'h01, 1'b0);
    checkOutput("post_rst_transient", int'(transient_steps), 6);

    for (int r = 0; r < 12; r++) applyStimulus(3, 8'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("final_done_count", doneCount, runsDone);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
